// File: rtl/spi_shift_emu.sv
// rtl/spi_shift_emu.sv - multi-channel SPI slave shift-register emulator
//
// Optional feature macro: SPI_SHIFT_EMU_ERRCNT_EN (adds err_clr / err_cnt)
//
// Ports:
//   clk         system clock; one SPI bit per rising edge while cs_b is low
//   rst         synchronous active-high reset
//   spi_sel     binary channel select, latched on the first cs_b-low cycle
//   cs_b        active-low chip select
//   mosi        serial data in
//   clk_out     clk pass-through
//   miso        serial data out of the active channel (combinational)
//   rx_data     last completed frame of the channel that received it
//   rx_ch       channel index belonging to rx_data
//   rx_valid    one-cycle pulse when rx_data/rx_ch update
//   frame_abort one-cycle pulse when cs_b rises mid-frame
//   busy        high while a chip-select assertion is being serviced
//   err_clr     (optional) synchronous clear of err_cnt, wins over increment
//   err_cnt     (optional) saturating count of frame_abort pulses
module spi_shift_emu #(
  parameter int NUM_CH    = 2,
  parameter int FRAME_W   = 40,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH_W-1:0]    spi_sel,
  input  logic               cs_b,
  input  logic               mosi,
  output logic               clk_out,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic [CH_W-1:0]    rx_ch,
  output logic               rx_valid,
  output logic               frame_abort,
  output logic               busy
`ifdef SPI_SHIFT_EMU_ERRCNT_EN
  ,
  input  logic               err_clr,
  output logic [7:0]         err_cnt
`endif
);

  localparam int CNT_W = $clog2(FRAME_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  state_t             next_state;
  logic [CH_W-1:0]    lock_ch;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] sr [NUM_CH];

  logic [CH_W-1:0]    act_ch;
  logic               ch_ok;
  logic [FRAME_W-1:0] act_bits;
  logic [FRAME_W-1:0] shifted;
  logic               last_bit;

  assign clk_out  = clk;
  assign last_bit = (bit_cnt == CNT_W'(FRAME_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!cs_b) next_state = SHIFT;
      SHIFT:   if (cs_b)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / channel-select logic. The select is live in IDLE so the very
  // first bit of an assertion already goes to the newly chosen channel.
  // An unimplemented select yields all-zero bits: nothing shifts, miso is 0.
  always_comb begin
    busy     = (state == SHIFT);
    act_ch   = busy ? lock_ch : spi_sel;
    ch_ok    = 1'b0;
    act_bits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (act_ch == CH_W'(i)) begin
        ch_ok    = 1'b1;
        act_bits = sr[i];
      end
    end
    shifted = MSB_FIRST ? {act_bits[FRAME_W-2:0], mosi}
                        : {mosi, act_bits[FRAME_W-1:1]};
    miso    = MSB_FIRST ? act_bits[FRAME_W-1] : act_bits[0];
  end

  // Shift registers: only the active channel moves, others hold their data
  // so a later frame on them replays what they last received.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) sr[i] <= '0;
    end else if (!cs_b) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (act_ch == CH_W'(i)) sr[i] <= shifted;
      end
    end
  end

  // Frame counting, capture and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_ch     <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_ch       <= '0;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      if (state == IDLE) begin
        if (!cs_b) begin
          lock_ch <= spi_sel;
          bit_cnt <= CNT_W'(1);
        end
      end else if (!cs_b) begin
        if (last_bit) begin
          bit_cnt  <= '0;
          rx_valid <= 1'b1;
          rx_data  <= ch_ok ? shifted : '0;
          rx_ch    <= lock_ch;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else begin
        // Release on a frame boundary is clean; anywhere else is an abort.
        if (bit_cnt != '0) frame_abort <= 1'b1;
        bit_cnt <= '0;
      end
    end
  end

`ifdef SPI_SHIFT_EMU_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt <= '0;
    end else if (frame_abort && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
